// File: rtl/lsu_mem_bridge_if.sv
// Bus interfaces for the LSU-to-memory bridge: the LSU request/response
// channel and the variable-latency memory port.
interface lsu_req_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wmask;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_err;

    // master = load/store unit, slave = bridge
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface mem_bus_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic                  mem_valid;
    logic                  mem_ready;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wmask;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_err;

    // master = bridge, slave = memory
    modport master (
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_ready, mem_rdata, mem_err
    );
    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_ready, mem_rdata, mem_err
    );
endinterface

// File: rtl/lsu_mem_bridge.sv
// Single-outstanding bridge from the LSU to a variable-latency memory port,
// with alignment / empty-mask screening and a timeout guard.
module lsu_mem_bridge #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic     clk,
    input  logic     rst,
    lsu_req_if.slave lsu,
    mem_bus_if.master mem
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT - 1);

    state_t      state_reg;
    logic [15:0] count_reg;

    assign lsu.req_ready = (state_reg == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            lsu.resp_valid <= 1'b0;
            lsu.resp_err   <= 1'b0;
            lsu.resp_rdata <= '0;
            mem.mem_valid  <= 1'b0;
            mem.mem_we     <= 1'b0;
            mem.mem_addr   <= '0;
            mem.mem_wdata  <= '0;
            mem.mem_wmask  <= '0;
        end else begin
            lsu.resp_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (lsu.req_valid) begin
                        if (lsu.req_addr[2:0] != 3'b000) begin
                            lsu.resp_err   <= 1'b1;
                            lsu.resp_rdata <= '0;
                            lsu.resp_valid <= 1'b1;
                            state_reg      <= RESP;
                        end else if (lsu.req_we && lsu.req_wmask == '0) begin
                            // Store with no enabled lanes completes without touching memory
                            lsu.resp_err   <= 1'b0;
                            lsu.resp_rdata <= '0;
                            lsu.resp_valid <= 1'b1;
                            state_reg      <= RESP;
                        end else begin
                            mem.mem_valid <= 1'b1;
                            mem.mem_we    <= lsu.req_we;
                            mem.mem_addr  <= lsu.req_addr;
                            mem.mem_wdata <= lsu.req_wdata;
                            mem.mem_wmask <= lsu.req_we ? lsu.req_wmask : '0;
                            count_reg     <= '0;
                            state_reg     <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // Handshake is checked first so a late mem_ready still wins over timeout
                    if (mem.mem_ready) begin
                        mem.mem_valid  <= 1'b0;
                        lsu.resp_rdata <= (!mem.mem_we && !mem.mem_err) ? mem.mem_rdata : '0;
                        lsu.resp_err   <= mem.mem_err;
                        lsu.resp_valid <= 1'b1;
                        state_reg      <= RESP;
                    end else if (count_reg == LAST_COUNT) begin
                        mem.mem_valid  <= 1'b0;
                        lsu.resp_err   <= 1'b1;
                        lsu.resp_rdata <= '0;
                        lsu.resp_valid <= 1'b1;
                        state_reg      <= RESP;
                    end else begin
                        count_reg <= count_reg + 16'd1;
                    end
                end
                RESP:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Directed bench for lsu_mem_bridge with a short timeout so the guard path is reachable.
module tb_lsu_mem_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   n_valid;

    always #5 clk = ~clk;

    lsu_req_if #(.ADDR_W(64), .DATA_W(64)) lsu ();
    mem_bus_if #(.ADDR_W(64), .DATA_W(64)) mem ();

    lsu_mem_bridge #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .lsu (lsu),
        .mem (mem)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic we, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [7:0] wmask);
        lsu.req_valid = 1'b1;
        lsu.req_we    = we;
        lsu.req_addr  = addr;
        lsu.req_wdata = wdata;
        lsu.req_wmask = wmask;
    endtask

    task automatic read_hit(input string tag, input logic [63:0] addr, input logic [63:0] data);
        request(1'b0, addr, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF);
        tick();
        lsu.req_valid = 1'b0;
        chk({tag, "_mem_valid"}, 64'(mem.mem_valid), 64'd1);
        chk({tag, "_mem_addr"}, mem.mem_addr, addr);
        chk({tag, "_mem_wmask"}, 64'(mem.mem_wmask), 64'h0);
        chk({tag, "_mem_we"}, 64'(mem.mem_we), 64'd0);
        chk({tag, "_req_ready"}, 64'(lsu.req_ready), 64'd0);
        mem.mem_ready = 1'b1;
        mem.mem_rdata = data;
        tick();
        mem.mem_ready = 1'b0;
        chk({tag, "_resp_valid"}, 64'(lsu.resp_valid), 64'd1);
        chk({tag, "_rdata"}, lsu.resp_rdata, data);
        chk({tag, "_err"}, 64'(lsu.resp_err), 64'd0);
        chk({tag, "_mem_valid_drop"}, 64'(mem.mem_valid), 64'd0);
        $display("txn %s read addr=%h rdata=%h err=%0d", tag, addr, lsu.resp_rdata, lsu.resp_err);
        tick();
        chk({tag, "_resp_pulse_end"}, 64'(lsu.resp_valid), 64'd0);
        chk({tag, "_ready_again"}, 64'(lsu.req_ready), 64'd1);
    endtask

    initial begin
        lsu.req_valid = 1'b0;
        lsu.req_we    = 1'b0;
        lsu.req_addr  = '0;
        lsu.req_wdata = '0;
        lsu.req_wmask = '0;
        mem.mem_ready = 1'b0;
        mem.mem_rdata = '0;
        mem.mem_err   = 1'b0;

        // reset
        #2 rst = 1'b0;
        tick();
        tick();
        chk("rst_mem_valid", 64'(mem.mem_valid), 64'd0);
        chk("rst_resp_valid", 64'(lsu.resp_valid), 64'd0);
        chk("rst_resp_rdata", lsu.resp_rdata, 64'd0);
        chk("rst_resp_err", 64'(lsu.resp_err), 64'd0);
        chk("rst_mem_addr", mem.mem_addr, 64'd0);
        chk("rst_mem_wmask", 64'(mem.mem_wmask), 64'd0);
        rst = 1'b1;
        tick();
        chk("rst_req_ready", 64'(lsu.req_ready), 64'd1);
        $display("txn reset done");

        // read hit, 2-cycle latency
        read_hit("rd_hit", 64'h0000_0000_8000_0010, 64'h1122_3344_5566_7788);

        // write with 3 wait states; ready arrives on the last allowed BUSY cycle
        request(1'b1, 64'h0000_0000_8000_0008, 64'hDEAD_BEEF_0000_0000, 8'hF0);
        tick();
        lsu.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("wr_mem_valid", 64'(mem.mem_valid), 64'd1);
            chk("wr_mem_addr", mem.mem_addr, 64'h0000_0000_8000_0008);
            chk("wr_mem_wdata", mem.mem_wdata, 64'hDEAD_BEEF_0000_0000);
            chk("wr_mem_wmask", 64'(mem.mem_wmask), 64'hF0);
            chk("wr_mem_we", 64'(mem.mem_we), 64'd1);
            chk("wr_req_ready", 64'(lsu.req_ready), 64'd0);
            chk("wr_no_early_resp", 64'(lsu.resp_valid), 64'd0);
            if (i == 3) mem.mem_ready = 1'b1;
            tick();
        end
        mem.mem_ready = 1'b0;
        chk("wr_resp_valid", 64'(lsu.resp_valid), 64'd1);
        chk("wr_rdata", lsu.resp_rdata, 64'd0);
        chk("wr_err", 64'(lsu.resp_err), 64'd0);
        chk("wr_mem_valid_drop", 64'(mem.mem_valid), 64'd0);
        $display("txn write addr=80000008 err=%0d", lsu.resp_err);
        tick();
        chk("wr_resp_pulse_end", 64'(lsu.resp_valid), 64'd0);

        // refill rdata so the next error responses must clear it
        read_hit("rd_fill1", 64'h0000_0000_8000_0018, 64'hA5A5_A5A5_5A5A_5A5A);

        // misaligned read
        request(1'b0, 64'h0000_0000_8000_0003, 64'd0, 8'hFF);
        tick();
        lsu.req_valid = 1'b0;
        chk("mis_mem_valid", 64'(mem.mem_valid), 64'd0);
        chk("mis_resp_valid", 64'(lsu.resp_valid), 64'd1);
        chk("mis_err", 64'(lsu.resp_err), 64'd1);
        chk("mis_rdata", lsu.resp_rdata, 64'd0);
        $display("txn misaligned addr=80000003 err=%0d", lsu.resp_err);
        tick();
        chk("mis_ready_again", 64'(lsu.req_ready), 64'd1);

        // empty-mask write
        request(1'b1, 64'h0000_0000_8000_0028, 64'h1234_5678_9ABC_DEF0, 8'h00);
        tick();
        lsu.req_valid = 1'b0;
        chk("empty_mem_valid", 64'(mem.mem_valid), 64'd0);
        chk("empty_resp_valid", 64'(lsu.resp_valid), 64'd1);
        chk("empty_err", 64'(lsu.resp_err), 64'd0);
        $display("txn empty-mask write err=%0d", lsu.resp_err);
        tick();

        read_hit("rd_fill2", 64'h0000_0000_8000_0030, 64'hCAFE_F00D_1234_5678);

        // timeout: TIMEOUT=4 gives exactly 4 cycles of mem_valid
        request(1'b0, 64'h0000_0000_8000_0020, 64'd0, 8'h00);
        tick();
        lsu.req_valid = 1'b0;
        n_valid = 0;
        for (int i = 0; i < 10 && mem.mem_valid; i++) begin
            n_valid++;
            tick();
        end
        chk("to_valid_cycles", 64'(n_valid), 64'd4);
        chk("to_resp_valid", 64'(lsu.resp_valid), 64'd1);
        chk("to_err", 64'(lsu.resp_err), 64'd1);
        chk("to_rdata", lsu.resp_rdata, 64'd0);
        $display("txn timeout busy_cycles=%0d err=%0d", n_valid, lsu.resp_err);
        tick();

        read_hit("rd_fill3", 64'h0000_0000_8000_0038, 64'h0F0F_0F0F_F0F0_F0F0);

        // bus error on a read
        request(1'b0, 64'h0000_0000_8000_0040, 64'd0, 8'h00);
        tick();
        lsu.req_valid = 1'b0;
        mem.mem_ready = 1'b1;
        mem.mem_err   = 1'b1;
        mem.mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        mem.mem_ready = 1'b0;
        mem.mem_err   = 1'b0;
        chk("berr_resp_valid", 64'(lsu.resp_valid), 64'd1);
        chk("berr_err", 64'(lsu.resp_err), 64'd1);
        chk("berr_rdata", lsu.resp_rdata, 64'd0);
        $display("txn bus-error read err=%0d", lsu.resp_err);
        tick();

        // reset in the middle of BUSY
        request(1'b0, 64'h0000_0000_8000_0048, 64'd0, 8'h00);
        tick();
        lsu.req_valid = 1'b0;
        chk("mid_mem_valid_before", 64'(mem.mem_valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_mem_valid_async_drop", 64'(mem.mem_valid), 64'd0);
        tick();
        chk("mid_no_resp_in_rst", 64'(lsu.resp_valid), 64'd0);
        rst = 1'b1;
        tick();
        chk("mid_no_resp_after", 64'(lsu.resp_valid), 64'd0);
        chk("mid_req_ready", 64'(lsu.req_ready), 64'd1);
        $display("txn reset mid-busy");
        read_hit("rd_after_rst", 64'h0000_0000_8000_0050, 64'h0102_0304_0506_0708);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsu_mem_bridge.md
Name: lsu_mem_bridge

Overview:
- Sits directly downstream of the load/store unit and replaces its direct DPI memory access.
- Accepts one doubleword-aligned read or write request at a time, with address, data and byte mask already formed by the LSU, over a valid/ready handshake.
- Drives a variable-latency memory port, with a timeout guard, and returns load data or a completion as a one-cycle response pulse.

Parameters:
- ADDR_W, 64, request/memory address width.
- DATA_W, 64, data width (the byte-mask width is DATA_W/8).
- TIMEOUT, 255, maximum BUSY cycles to wait for mem_ready before an error response; must be 1..65535.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  LSU request valid.
- req_ready  out  1  bridge can accept a request.
- req_we  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  byte address; bits [2:0] must be 0.
- req_wdata  in  DATA_W  store data, already lane-aligned.
- req_wmask  in  DATA_W/8  byte write strobes.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  load data; 0 for writes and errors.
- resp_err  out  1  error flag, qualified by resp_valid.
- mem_valid  out  1  memory request valid.
- mem_ready  in  1  memory accepts the request / read data is valid.
- mem_we  out  1  registered copy of req_we.
- mem_addr  out  ADDR_W  registered copy of req_addr.
- mem_wdata  out  DATA_W  registered copy of req_wdata.
- mem_wmask  out  DATA_W/8  registered copy of req_wmask; forced to 0 on reads.
- mem_rdata  in  DATA_W  read data, sampled when mem_valid & mem_ready.
- mem_err  in  1  bus error, sampled when mem_valid & mem_ready.

Behaviour:
- FSM states: IDLE, BUSY, RESP.
- Reset (rst=0, asynchronous) forces:
  - state=IDLE and timeout counter=0;
  - every output register to 0: resp_valid, resp_err, resp_rdata, mem_valid and all mem_* outputs;
  - req_ready=1 once rst=1.
- Reset in the middle of a transaction drops mem_valid immediately (asynchronously). No response is generated for the aborted request.
- req_ready is 1 only in IDLE (combinational from state). A request is accepted on a rising edge where req_valid & req_ready.
- Decisions on acceptance, taken in IDLE:
  - req_addr[2:0]!=0: go to RESP with err=1, rdata=0. No memory access.
  - req_we=1 and req_wmask==0: go to RESP with err=0. No memory access.
  - Otherwise: latch we/addr/wdata/mask into the mem_* registers, set mem_valid=1, clear the counter, go to BUSY.
- BUSY:
  - mem_valid and all mem_* outputs stay stable until handshake or timeout.
  - On mem_valid & mem_ready: mem_valid goes to 0 next cycle. Latch resp_rdata = (read & !mem_err) ? mem_rdata : 0 and resp_err = mem_err, then go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without mem_ready: mem_valid goes to 0, resp_err=1, resp_rdata=0, go to RESP.
  - A mem_ready on the timeout cycle itself counts as success; success has priority over timeout.
- RESP:
  - resp_valid=1 for exactly one cycle, then back to IDLE with req_ready=1.
  - The consumer always accepts; there is no backpressure on the response.
  - resp_rdata and resp_err keep their values until the next RESP.
  - resp_valid=0 in every other state.
- Latency:
  - Accept at edge N: mem_valid=1 during cycle N+1.
  - mem_ready=1 in cycle N+1+k: resp_valid=1 in cycle N+2+k.
  - Minimum accept-to-response is 2 cycles.
  - Earliest next acceptance is the cycle after resp_valid.
- req_valid while req_ready=0 is ignored, not queued. The LSU holds the request until it is accepted.
- mem_ready and mem_err are ignored whenever mem_valid=0.

Test Plan:
- Read hit: req read addr=0x80000010. mem_ready=1 in the first BUSY cycle with mem_rdata=0x1122334455667788 -> mem_wmask=0; resp_valid 2 cycles after acceptance with rdata=0x1122334455667788, err=0.
- Write with wait states: addr=0x80000008, wdata=0xDEADBEEF00000000, wmask=0xF0, mem_ready delayed 3 cycles -> mem_* outputs stable for 4 cycles; resp_valid at cycle 5, rdata=0, err=0; req_ready low throughout.
- Misaligned and empty-mask requests:
  - read addr=0x80000003 -> no mem_valid; resp_valid next cycle with err=1.
  - write with wmask=0x00 -> no mem_valid; err=0.
- Timeout: TIMEOUT=4, mem_ready held 0 -> mem_valid for exactly 4 cycles, then resp err=1, rdata=0.
- Bus error: read with mem_ready=1 and mem_err=1, mem_rdata=0xFFFF... -> resp err=1, rdata=0.
- Reset mid-BUSY: drop rst while mem_valid=1 -> mem_valid=0 immediately and no resp_valid. After release, a new read completes normally with req_ready=1.
